// File: rtl/lru_age_tracker_pkg.sv
// lru_age_tracker_pkg: shared widths, FSM encoding and age type for the LRU age tracker
package lru_age_tracker_pkg;
  localparam int SET_W = 4;
  localparam int WAY_W = 3;
  localparam int NUM_SETS = 2 ** SET_W;
  localparam int NUM_WAYS = 2 ** WAY_W;
  typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, DONE = 2'd2} state_t;
  typedef logic [WAY_W-1:0] age_t;
endpackage

// File: rtl/lru_age_tracker_age_gt_cmp.sv
// age_gt_cmp: combinational strict greater-than between two ages
module age_gt_cmp
  import lru_age_tracker_pkg::*;
(
  input  age_t a_i,
  input  age_t b_i,
  output logic gt_o
);
  assign gt_o = a_i > b_i;
endmodule

// File: rtl/lru_age_tracker.sv
// lru_age_tracker: per-set LRU ages with 1-cycle updates and a sequential oldest-way victim scan
module lru_age_tracker
  import lru_age_tracker_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             upd_valid_i,
  input  logic [SET_W-1:0] upd_set_i,
  input  logic [WAY_W-1:0] upd_way_i,
  input  logic             vic_valid_i,
  input  logic [SET_W-1:0] vic_set_i,
  output logic             ready_o,
  output logic             vic_done_o,
  output logic [WAY_W-1:0] vic_way_o
);
  state_t state_q, state_d;
  age_t age_q [NUM_SETS][NUM_WAYS];
  age_t row_d [NUM_WAYS];
  logic [SET_W-1:0] set_q, set_d;
  logic [WAY_W-1:0] idx_q, idx_d, best_way_q, best_way_d, vic_way_q, vic_way_d;
  age_t best_age_q, best_age_d, scan_age, old_age;
  logic vic_done_q, vic_done_d, gt, upd_fire, vic_fire;
  assign ready_o = state_q == IDLE;
  assign upd_fire = ready_o && upd_valid_i;
  assign vic_fire = ready_o && vic_valid_i && !upd_valid_i;
  assign vic_done_o = vic_done_q;
  assign vic_way_o = vic_way_q;
  assign old_age = age_q[upd_set_i][upd_way_i];
  assign scan_age = age_q[set_q][idx_q];
  for (genvar w = 0; w < NUM_WAYS; w++) begin : g_way
    assign row_d[w] = WAY_W'(w) == upd_way_i ? '0
                    : age_q[upd_set_i][w] < old_age ? age_q[upd_set_i][w] + 1'b1
                    : age_q[upd_set_i][w];
  end
  age_gt_cmp u_cmp (.a_i(scan_age), .b_i(best_age_q), .gt_o(gt));
  always_comb begin
    state_d = state_q;
    set_d = set_q;
    idx_d = idx_q;
    best_way_d = best_way_q;
    best_age_d = best_age_q;
    vic_way_d = vic_way_q;
    vic_done_d = 1'b0;
    case (state_q)
      IDLE: if (vic_fire) begin
        set_d = vic_set_i;
        idx_d = WAY_W'(1);
        best_way_d = '0;
        best_age_d = age_q[vic_set_i][0];
        state_d = SCAN;
      end
      SCAN: begin
        best_way_d = gt ? idx_q : best_way_q;
        best_age_d = gt ? scan_age : best_age_q;
        idx_d = idx_q + 1'b1;
        state_d = idx_q == WAY_W'(NUM_WAYS - 1) ? DONE : SCAN;
      end
      DONE: begin
        vic_way_d = best_way_q;
        vic_done_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      set_q <= '0;
      idx_q <= '0;
      best_way_q <= '0;
      best_age_q <= '0;
      vic_way_q <= '0;
      vic_done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      set_q <= set_d;
      idx_q <= idx_d;
      best_way_q <= best_way_d;
      best_age_q <= best_age_d;
      vic_way_q <= vic_way_d;
      vic_done_q <= vic_done_d;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < NUM_SETS; s++)
        for (int w = 0; w < NUM_WAYS; w++)
          age_q[s][w] <= age_t'(w);
    end else if (upd_fire) begin
      for (int w = 0; w < NUM_WAYS; w++)
        age_q[upd_set_i][w] <= row_d[w];
    end
  end
endmodule

// File: tb/tb_lru_age_tracker.sv
// tb_lru_age_tracker: directed plus random checks of the age tracker against a reference model
module tb_lru_age_tracker;
  import lru_age_tracker_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic upd_valid = 1'b0;
  logic [SET_W-1:0] upd_set = '0;
  logic [WAY_W-1:0] upd_way = '0;
  logic vic_valid = 1'b0;
  logic [SET_W-1:0] vic_set = '0;
  logic ready, vic_done;
  logic [WAY_W-1:0] vic_way;
  int m [NUM_SETS][NUM_WAYS];
  int n_chk = 0;
  int n_fail = 0;
  lru_age_tracker dut (
    .clk(clk), .rst(rst),
    .upd_valid_i(upd_valid), .upd_set_i(upd_set), .upd_way_i(upd_way),
    .vic_valid_i(vic_valid), .vic_set_i(vic_set),
    .ready_o(ready), .vic_done_o(vic_done), .vic_way_o(vic_way)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic model_reset();
    for (int s = 0; s < NUM_SETS; s++)
      for (int w = 0; w < NUM_WAYS; w++)
        m[s][w] = w;
  endtask
  function automatic int model_victim(input int s);
    int bw = 0;
    for (int w = 1; w < NUM_WAYS; w++)
      if (m[s][w] > m[s][bw]) bw = w;
    return bw;
  endfunction
  task automatic upd(input int s, input int w);
    int old = m[s][w];
    upd_valid = 1'b1;
    upd_set = SET_W'(s);
    upd_way = WAY_W'(w);
    tick();
    upd_valid = 1'b0;
    for (int v = 0; v < NUM_WAYS; v++)
      if (v == w) m[s][v] = 0;
      else if (m[s][v] < old) m[s][v]++;
  endtask
  task automatic query(input int s, input string tag);
    int exp_w = model_victim(s);
    int cyc = 0;
    int low = 0;
    vic_valid = 1'b1;
    vic_set = SET_W'(s);
    tick();
    vic_valid = 1'b0;
    while (!vic_done && cyc < 20) begin
      if (!ready) low++;
      tick();
      cyc++;
    end
    chk({tag, "_latency"}, cyc, NUM_WAYS);
    chk({tag, "_vic_way"}, vic_way, exp_w);
    chk({tag, "_ready_low"}, low, NUM_WAYS);
    tick();
    chk({tag, "_pulse"}, vic_done, 0);
  endtask
  task automatic cmp_all(input string tag);
    for (int s = 0; s < NUM_SETS; s++)
      for (int w = 0; w < NUM_WAYS; w++)
        chk($sformatf("%s_age_s%0dw%0d", tag, s, w), dut.age_q[s][w], m[s][w]);
  endtask
  initial begin
    model_reset();
    tick();
    tick();
    rst = 1'b0;
    chk("rst_ready", ready, 1);
    chk("rst_vic_done", vic_done, 0);
    chk("rst_vic_way", vic_way, 0);
    cmp_all("rst");
    query(0, "q_set0");
    chk("set0_fixed", vic_way, 7);
    upd(3, 7);
    chk("upd_ready", ready, 1);
    query(3, "q_set3");
    chk("set3_fixed", vic_way, 6);
    query(4, "q_set4");
    chk("set4_fixed", vic_way, 7);
    upd(5, 2);
    upd(5, 2);
    query(5, "q_set5");
    chk("set5_fixed", vic_way, 7);
    for (int w = 7; w >= 1; w--) upd(1, w);
    query(1, "q_set1_a");
    chk("set1_a_fixed", vic_way, 0);
    upd(1, 0);
    query(1, "q_set1_b");
    chk("set1_b_fixed", vic_way, 7);
    cmp_all("dir");
    upd_valid = 1'b1;
    upd_set = SET_W'(6);
    upd_way = WAY_W'(7);
    vic_valid = 1'b1;
    vic_set = SET_W'(6);
    tick();
    upd_valid = 1'b0;
    for (int v = 0; v < NUM_WAYS; v++) m[6][v] = v == 7 ? 0 : m[6][v] + 1;
    chk("both_ready", ready, 1);
    chk("both_no_done", vic_done, 0);
    query(6, "q_both");
    chk("both_fixed", vic_way, 6);
    vic_valid = 1'b1;
    vic_set = SET_W'(3);
    tick();
    vic_valid = 1'b0;
    chk("abort_busy", ready, 0);
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_reset();
    chk("abort_ready", ready, 1);
    begin
      int seen = 0;
      for (int i = 0; i < 12; i++) begin
        if (vic_done) seen++;
        tick();
      end
      chk("abort_no_done", seen, 0);
    end
    cmp_all("abort");
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) < 8) upd($urandom_range(0, NUM_SETS - 1), $urandom_range(0, NUM_WAYS - 1));
      else query($urandom_range(0, NUM_SETS - 1), "q_rand");
    end
    cmp_all("rand");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/lru_age_tracker.md
Name: lru_age_tracker

Overview:
- Maintains the per-set LRU age counters of the set-associative cache.
- Accepts hit/fill updates from the cache controller and rewrites the ages of one set.
- Accepts victim queries and scans the set's ages sequentially with a strict greater-than comparator. It returns the oldest way.
- Sits between the cache controller and the tag/data arrays; it owns all replacement state.

Parameters:
- SET_W, 4, set index width; NUM_SETS = 2**SET_W.
- WAY_W, 3, way index width and age width; NUM_WAYS = 2**WAY_W.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- upd_valid  input  1  update request: way upd_way of set upd_set was accessed (hit or fill).
- upd_set  input  SET_W  set index for update.
- upd_way  input  WAY_W  accessed way.
- vic_valid  input  1  victim query request.
- vic_set  input  SET_W  set index to query.
- ready  output  1  block idle; a request is accepted on a rising edge where ready=1 and its valid=1.
- vic_done  output  1  one-cycle pulse; vic_way is valid.
- vic_way  output  WAY_W  selected victim (oldest way); held until next vic_done.

Behaviour:
- Storage: NUM_SETS x NUM_WAYS registers of WAY_W bits, age[s][w].
- Reset, synchronous and active-high:
  - age[s][w] = w for all s, w.
  - FSM to IDLE; ready=1, vic_done=0, vic_way=0.
  - Reset mid-scan aborts the scan; no vic_done is issued.
- Invariant: the ages in every set form a permutation of 0..NUM_WAYS-1. Counters therefore never overflow.
- FSM states: IDLE, SCAN, DONE.
  - ready=1 only in IDLE.
- IDLE:
  - If upd_valid=1, apply the update in the same edge and stay in IDLE. Update latency is 1 cycle.
  - Else if vic_valid=1, accept the query:
    - latch vic_set
    - best_way=0, best_age=age[set][0], idx=1
    - go to SCAN
  - If both upd_valid and vic_valid are 1, the update wins. The query is not accepted, and the requester holds vic_valid.
- Update rule, with old = age[set][upd_way]:
  - way upd_way gets 0;
  - any way with age < old gets age+1;
  - every other way is unchanged.
  - An update to an already-MRU way (old=0) changes nothing.
- SCAN, one way per cycle:
  - If age[set][idx] > best_age (strict compare), then best_way=idx and best_age=age[set][idx].
  - On ties the lower index is kept.
  - When idx = NUM_WAYS-1 is processed, go to DONE; otherwise idx+1.
- DONE:
  - vic_way=best_way, vic_done=1 for exactly one cycle, then IDLE.
- Query latency: vic_done is high NUM_WAYS cycles after the acceptance edge, i.e. 8 for the defaults.
- Ages are not modified by a query. The controller issues the fill update separately.
- No update can interleave with a scan, because ready=0 during SCAN/DONE.
- Out-of-range indices cannot occur; all index widths exactly match the array size.

Decomposition:
- Shared package:
  - SET_W, WAY_W defaults and NUM_SETS/NUM_WAYS derivations;
  - FSM state encoding (IDLE=2'd0, SCAN=2'd1, DONE=2'd2);
  - age_t typedef (WAY_W bits).
- One natural sub-module: age_gt_cmp. It is a combinational WAY_W-bit strict greater-than, instantiated once in the scan datapath.
- The update logic stays inline as a generate loop over ways.

Test Plan:
- Reset, then query set 0 -> vic_done 8 cycles after acceptance, vic_way=7; ready low for exactly those 8 cycles.
- Set 3, update way 7 -> ages become {1,2,3,4,5,6,7,0}; query set 3 -> vic_way=6; set 4 is untouched, query -> 7.
- Set 5, updates way 2 then way 2 again -> the second update leaves the ages unchanged: {1,2,0,3,4,5,6,7}; query -> 7.
- Set 1, update ways 7,6,5,4,3,2,1 in sequence -> victim is way 0. Then update way 0 -> victim is way 7, and every set still holds a permutation.
- upd_valid and vic_valid both asserted in IDLE -> update applied, query not accepted. Query accepted on the next cycle if still held; result reflects the updated ages.
- Query accepted, rst asserted at scan cycle 4 -> no vic_done; ready=1 next cycle; all ages back to age[s][w]=w.
